mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 109 ++++++++++
 tb/tb_mem_loader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: streams host bytes into a RAM and optionally reads them back to verify a checksum
module mem_loader #(
  parameter bit VERIFY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] base,
  input  logic [7:0] count,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] addr,
  output logic [7:0] data_out,
  output logic       wren,
  output logic       rden,
  input  logic [7:0] q,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] checksum
);
  typedef enum logic [2:0] {IDLE, WRITE, VRD, VACC, VCHK, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] ptr_q, ptr_d, sum_q, sum_d, rsum_q, rsum_d, base_q, base_d;
  logic [8:0] rem_q, rem_d, cnt_q, cnt_d;
  logic err_q, err_d, hs, last;
  assign hs = (state_q == WRITE) && in_valid;
  assign last = rem_q == 9'd1;
  assign err = err_q;
  assign checksum = sum_q;
  // state and datapath registers, cleared asynchronously by active-low rst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 8'd0;
      rem_q   <= 9'd0;
      sum_q   <= 8'd0;
      rsum_q  <= 8'd0;
      err_q   <= 1'b0;
      base_q  <= 8'd0;
      cnt_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      sum_q   <= sum_d;
      rsum_q  <= rsum_d;
      err_q   <= err_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end
  // next-state: write phase, optional two-cycle-per-byte read-back, check, done pulse
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? WRITE : IDLE;
      WRITE:   if (hs && last) state_d = VERIFY_EN ? VRD : DONE;
      VRD:     state_d = VACC;
      VACC:    state_d = last ? VCHK : VRD;
      VCHK:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // datapath: pointer/remaining count, write sum, read-back sum and mismatch flag
  always_comb begin
    ptr_d  = ptr_q;
    rem_d  = rem_q;
    sum_d  = sum_q;
    rsum_d = rsum_q;
    err_d  = err_q;
    base_d = base_q;
    cnt_d  = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        base_d = base;
        cnt_d  = {count == 8'd0, count};
        ptr_d  = base;
        rem_d  = {count == 8'd0, count};
        sum_d  = 8'd0;
        rsum_d = 8'd0;
        err_d  = 1'b0;
      end
      WRITE: if (hs) begin
        ptr_d = last ? base_q : ptr_q + 8'd1;
        rem_d = last ? cnt_q : rem_q - 9'd1;
        sum_d = sum_q + in_data;
      end
      VACC: begin
        rsum_d = rsum_q + q;
        ptr_d  = ptr_q + 8'd1;
        rem_d  = rem_q - 9'd1;
      end
      VCHK: err_d = sum_q != rsum_q;
      default: ;
    endcase
  end
  // outputs: write bus is combinational on the host byte, buses idle at zero otherwise
  always_comb begin
    in_ready = state_q == WRITE;
    wren     = hs;
    rden     = state_q == VRD;
    addr     = (state_q == WRITE || state_q == VRD || state_q == VACC) ? ptr_q : 8'd0;
    data_out = (state_q == WRITE) ? in_data : 8'd0;
    busy     = state_q != IDLE;
    done     = state_q == DONE;
  end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: randomized directed loads against a queue-based reference of the loader
module tb_mem_loader;
  logic clk = 1'b0, rst = 1'b0;
  logic start1 = 1'b0, start2 = 1'b0, in_valid = 1'b0;
  logic [7:0] base = 8'd0, count = 8'd0, in_data = 8'd0, q = 8'd0;
  logic r1_in_ready, r1_wren, r1_rden, r1_busy, r1_done, r1_err;
  logic [7:0] r1_addr, r1_data_out, r1_checksum;
  logic r2_in_ready, r2_wren, r2_rden, r2_busy, r2_done, r2_err;
  logic [7:0] r2_addr, r2_data_out, r2_checksum;
  logic o_in_ready, o_wren, o_rden, o_busy, o_done, o_err;
  logic [7:0] o_addr, o_data_out, o_checksum;
  bit sel = 1'b0;
  int checks = 0, errors = 0;
  logic [7:0] mem [256];
  logic bad_en = 1'b0;
  logic [7:0] bad_addr = 8'd0;

  always #5 clk = ~clk;

  mem_loader #(.VERIFY_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .base(base), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(r1_in_ready), .addr(r1_addr),
    .data_out(r1_data_out), .wren(r1_wren), .rden(r1_rden), .q(q), .busy(r1_busy),
    .done(r1_done), .err(r1_err), .checksum(r1_checksum));

  mem_loader #(.VERIFY_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .base(base), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(r2_in_ready), .addr(r2_addr),
    .data_out(r2_data_out), .wren(r2_wren), .rden(r2_rden), .q(q), .busy(r2_busy),
    .done(r2_done), .err(r2_err), .checksum(r2_checksum));

  assign o_in_ready = sel ? r2_in_ready : r1_in_ready;
  assign o_wren     = sel ? r2_wren     : r1_wren;
  assign o_rden     = sel ? r2_rden     : r1_rden;
  assign o_busy     = sel ? r2_busy     : r1_busy;
  assign o_done     = sel ? r2_done     : r1_done;
  assign o_err      = sel ? r2_err      : r1_err;
  assign o_addr     = sel ? r2_addr     : r1_addr;
  assign o_data_out = sel ? r2_data_out : r1_data_out;
  assign o_checksum = sel ? r2_checksum : r1_checksum;

  // RAM model on the verifying loader: write on the edge, registered read, optional corrupt cell
  always @(posedge clk) begin
    if (r1_wren) mem[r1_addr] <= r1_data_out;
    if (r1_rden) q <= (bad_en && r1_addr == bad_addr) ? 8'hFF : mem[r1_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_in_ready"}, o_in_ready, 0);
    chk({tag, "_wren"}, o_wren, 0);
    chk({tag, "_rden"}, o_rden, 0);
    chk({tag, "_addr"}, o_addr, 0);
    chk({tag, "_data_out"}, o_data_out, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
  endtask

  // one complete load; stall<0 gives the valid pattern 1,0,0,1,..; dm<0 random bytes else i+dm
  task automatic run_load(input bit v, input logic [7:0] b, input logic [7:0] c,
                          input int stall, input int dm, input bit poke);
    int n, sent, cyc, last_hs, done_cyc;
    logic [7:0] data[$], wa[$], wd[$], ra[$];
    logic [7:0] sum, rsum, a;
    logic exp_err;
    n = (c == 8'd0) ? 256 : int'(c);
    sent = 0; cyc = 0; last_hs = -1; done_cyc = -1;
    for (int i = 0; i < n; i++) data.push_back(dm < 0 ? 8'($urandom) : 8'(i + dm));
    sel = !v;
    @(negedge clk);
    base = b; count = c;
    if (v) start1 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    base = 8'($urandom); count = 8'($urandom);
    while (done_cyc < 0 && cyc < 3000) begin
      in_valid = (sent < n) && (stall < 0 ? (cyc % 3 == 0) : ($urandom_range(99) >= stall));
      in_data = in_valid ? data[sent] : 8'($urandom);
      if (poke && cyc == 1) begin
        base = b ^ 8'h55;
        if (v) start1 = 1'b1; else start2 = 1'b1;
      end else begin
        start1 = 1'b0; start2 = 1'b0;
      end
      #1;
      if (sent < n) begin
        chk("in_ready_write", o_in_ready, 1);
        chk("wren_follows_valid", o_wren, in_valid);
      end else chk("in_ready_after", o_in_ready, 0);
      chk("busy_in_load", o_busy, 1);
      chk("wren_rden_excl", o_wren & o_rden, 0);
      if (o_wren) begin wa.push_back(o_addr); wd.push_back(o_data_out); end
      if (o_rden) ra.push_back(o_addr);
      if (o_done) done_cyc = cyc;
      if (in_valid) begin sent++; if (sent == n) last_hs = cyc; end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; start1 = 1'b0; start2 = 1'b0;
    chk("done_seen", done_cyc >= 0, 1);
    chk("write_count", wa.size(), n);
    sum = 8'd0; rsum = 8'd0;
    for (int i = 0; i < n; i++) begin
      a = b + 8'(i);
      sum += data[i];
      rsum += (bad_en && a == bad_addr) ? 8'hFF : data[i];
      if (i < wa.size()) begin
        chk("write_addr", wa[i], a);
        chk("write_data", wd[i], data[i]);
      end
      if (v) begin
        chk("ram_content", mem[a], data[i]);
        if (i < ra.size()) chk("read_addr", ra[i], a);
      end
    end
    chk("read_count", ra.size(), v ? n : 0);
    chk("done_latency", done_cyc - last_hs, v ? 2 * n + 2 : 1);
    exp_err = v && (sum != rsum);
    #1;
    chk("done_one_cycle", o_done, 0);
    chk("checksum", o_checksum, sum);
    chk("err", o_err, exp_err);
    chk_idle_zero("post_load");
    repeat (3) @(negedge clk);
    #1;
    chk("checksum_hold", o_checksum, sum);
    chk("err_hold", o_err, exp_err);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    #1;
    sel = 1'b0; chk_idle_zero("rst1"); chk("rst1_err", o_err, 0); chk("rst1_cks", o_checksum, 0);
    sel = 1'b1; chk_idle_zero("rst2"); chk("rst2_err", o_err, 0); chk("rst2_cks", o_checksum, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    sel = 1'b0; #1; chk("idle_wait_busy", o_busy, 0);
    // basic load
    run_load(1'b1, 8'h10, 8'd3, 0, 1, 1'b0);
    chk("basic_cks", r1_checksum, 8'h06);
    chk("basic_err", r1_err, 0);
    // corrupted RAM cell
    bad_en = 1'b1; bad_addr = 8'h11;
    run_load(1'b1, 8'h10, 8'd3, 0, 1, 1'b0);
    chk("corrupt_err", r1_err, 1);
    chk("corrupt_cks", r1_checksum, 8'h06);
    bad_en = 1'b0;
    // wrapping 256-byte load
    run_load(1'b1, 8'hFE, 8'd0, 0, 0, 1'b0);
    chk("wrap_cks", r1_checksum, 8'h80);
    chk("wrap_err", r1_err, 0);
    // abort mid-load by reset
    sel = 1'b0;
    @(negedge clk); base = 8'h40; count = 8'd4; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    in_valid = 1'b1; in_data = 8'hA1;
    @(negedge clk); in_data = 8'hB2;
    @(negedge clk); in_data = 8'hC3;
    #1; chk("abort_pre_wren", o_wren, 1);
    rst = 1'b0;
    #1;
    chk_idle_zero("abort");
    chk("abort_err", o_err, 0);
    chk("abort_cks", o_checksum, 0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    chk("abort_mem40", mem[8'h40], 8'hA1);
    chk("abort_mem41", mem[8'h41], 8'hB2);
    chk("abort_mem42", mem[8'h42], 8'h44);
    repeat (2) @(negedge clk);
    #1; chk("abort_idle", o_busy, 0);
    // clean load after abort, with a start pulse while busy
    run_load(1'b1, 8'h40, 8'd4, 0, -1, 1'b1);
    // host stalls 1,0,0,1
    run_load(1'b1, 8'h80, 8'd2, -1, -1, 1'b0);
    // no verify pass
    run_load(1'b0, 8'h20, 8'd2, 0, -1, 1'b0);
    // randomized loads
    repeat (8) begin
      bit v;
      logic [7:0] b, c;
      v = 1'($urandom_range(1));
      b = 8'($urandom);
      c = 8'($urandom_range(20, 1));
      bad_en = v && ($urandom_range(1) == 1);
      bad_addr = b + 8'($urandom_range(int'(c) - 1));
      run_load(v, b, c, $urandom_range(50), -1, 1'($urandom_range(1)));
      bad_en = 1'b0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
